row_bank: RTL and testbench
===========================

ROW_BANK -- requirements
Module: row_bank

Interface
REQ-001 Parameter LENGTH, default 256, pixels per row (from essentials package).
REQ-002 Parameter HEIGHT, default 256, rows per frame; even, >= 4.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 pix_in  in  8  raster-order pixel stream, row-major.
REQ-006 pix_valid  in  1  pix_in valid; transfer when pix_valid && pix_ready.
REQ-007 pix_ready  out  1  bank accepting pixels.
REQ-008 next  in  1  one-cycle request from col_processor for next row triplet.
REQ-009 en  out  1  one-cycle pulse marking column 0 of a triplet.
REQ-010 row_0, row_1, row_2  out  8 each  same-column pixels of rows 2k, 2k+1, 2k+2.
REQ-011 busy  out  1  high in any state except IDLE_WAIT and DONE.
REQ-012 frame_done  out  1  one-cycle pulse after last triplet streamed.

Function
REQ-013 Storage: three LENGTH x 8 line buffers used as rotating ring; physical-to-logical mapping by 2-bit base pointer, no data copying.
REQ-014 States: FILL, STREAM, IDLE_WAIT, REFILL, DONE; reset state FILL.
REQ-015 FILL: pix_ready=1; accept 3*LENGTH pixels into logical rows 0,1,2; then STREAM next cycle.
REQ-016 STREAM: exactly LENGTH consecutive cycles, column index c=0..LENGTH-1; row_x outputs registered, valid same cycle as en; en=1 only at c=0; pix_ready=0.
REQ-017 After c=LENGTH-1: last triplet (k=HEIGHT/2-1) -> DONE; else IDLE_WAIT.
REQ-018 IDLE_WAIT: holds until next=1, then REFILL; next in any other state ignored.
REQ-019 REFILL: base pointer advances by 2 (mod 3), old row_2 becomes row_0; accept 2*LENGTH pixels into new logical rows 1,2; exception: final triplet accepts only LENGTH pixels (row 1) and row 2 is boundary-extended per REQ-027.
REQ-020 REFILL completes -> STREAM next cycle; triplet counter k increments.
REQ-021 DONE: frame_done pulses for one cycle on entry; next cycle returns to FILL for next frame; k cleared.
REQ-022 pix_valid low stalls FILL/REFILL indefinitely, no data loss; write address advances only on accepted transfers.
REQ-023 Write column counter wraps LENGTH-1 -> 0 and advances write row; read column counter wraps at LENGTH-1.
REQ-024 Outside STREAM row_0..row_2 hold last driven values; en=0.
REQ-025 Frame triplets: HEIGHT/2; total pixels accepted per frame = HEIGHT*LENGTH.

Reset
REQ-026 reset asserted any time (incl. mid-STREAM/REFILL): state=FILL, k=0, counters=0, base=0, en=0, frame_done=0, row_0..row_2=0, pix_ready=1 after release, busy=1; buffer contents undefined, not cleared.

Configuration
REQ-027 Macro ROW_BANK_MIRROR_EN: defined -> final triplet row_2 = row HEIGHT-2 (symmetric extension, read from row_0 buffer); undefined -> final triplet row_2 = 8'h00 (zero padding).

Verification
REQ-028 LENGTH=256,HEIGHT=4, pixel=(row*16+col)&8'hFF: after 768 accepted pixels, next cycle en=1, row_0=00,row_1=10,row_2=20; c=5 gives 05,15,25.
REQ-029 Same frame, next pulse after first STREAM: 256 pixels accepted, then row_0=20,row_1=30, row_2=20 (MIRROR_EN) or 00 (undefined); frame_done pulses 256 cycles later.
REQ-030 pix_valid toggled 50% during FILL: 768 transfers still required; stream output identical to REQ-028.
REQ-031 next asserted during STREAM and FILL: ignored; IDLE_WAIT persists until fresh next pulse.
REQ-032 reset asserted at STREAM c=100: next cycle en=0,rows=00,state FILL; new frame streams correctly from row 0.
REQ-033 HEIGHT=6, two frames back-to-back: 3 triplets each, frame_done pulses twice, second frame rows begin at its own row 0.

Source files
------------

// File: rtl/row_bank.sv
// row_bank: three rotating line buffers that stream vertical row triplets (2k, 2k+1, 2k+2).
// Build option ROW_BANK_MIRROR_EN: final triplet row_2 mirrors row HEIGHT-2 instead of zero padding.
module row_bank #(
  parameter int LENGTH = 256,
  parameter int HEIGHT = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       next,
  output logic       en,
  output logic [7:0] row_0,
  output logic [7:0] row_1,
  output logic [7:0] row_2,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int KW = $clog2(HEIGHT / 2 + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(LENGTH - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(HEIGHT / 2 - 1);
  localparam logic [KW-1:0] K_PRE    = KW'(HEIGHT / 2 - 2);

  typedef enum logic [2:0] {FILL, STREAM, IDLE_WAIT, REFILL, DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [3][LENGTH];
  logic [CW-1:0] wr_col, rd_col, rd_nxt;
  logic [1:0]    wr_row, base, end_row;
  logic [KW-1:0] k;
  logic          accept, fill_end, final_trip;
  logic [7:0]    pad_pix;

  // Logical row l lives in physical buffer (base + l) mod 3.
  function automatic logic [1:0] phys(input logic [1:0] b, input logic [1:0] l);
    logic [2:0] s;
    s = {1'b0, b} + {1'b0, l};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign accept     = pix_valid && pix_ready;
  assign end_row    = (state == REFILL && k == K_PRE) ? 2'd1 : 2'd2;
  assign fill_end   = accept && (wr_col == COL_LAST) && (wr_row == end_row);
  assign final_trip = (state == STREAM) ? (k == K_LAST) : (state == REFILL && k == K_PRE);
  assign rd_nxt     = (state == STREAM) ? rd_col + CW'(1) : '0;

`ifdef ROW_BANK_MIRROR_EN
  assign pad_pix = mem[phys(base, 2'd0)][rd_nxt];
`else
  assign pad_pix = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:      if (fill_end) state_nxt = STREAM;
      STREAM:    if (rd_col == COL_LAST) state_nxt = (k == K_LAST) ? DONE : IDLE_WAIT;
      IDLE_WAIT: if (next) state_nxt = REFILL;
      REFILL:    if (fill_end) state_nxt = STREAM;
      DONE:      state_nxt = FILL;
      default:   state_nxt = FILL;
    endcase
  end

  always_comb begin
    pix_ready = (state == FILL) || (state == REFILL);
    busy      = (state != IDLE_WAIT) && (state != DONE);
  end

  // Buffer contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) mem[phys(base, wr_row)][wr_col] <= pix_in;
  end

  // Outputs are loaded one edge ahead so they are valid in the same cycle as en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_col     <= '0;
      wr_row     <= '0;
      rd_col     <= '0;
      base       <= '0;
      k          <= '0;
      en         <= 1'b0;
      frame_done <= 1'b0;
      row_0      <= '0;
      row_1      <= '0;
      row_2      <= '0;
    end else begin
      if (accept) begin
        if (wr_col == COL_LAST) begin
          wr_col <= '0;
          wr_row <= wr_row + 2'd1;
        end else begin
          wr_col <= wr_col + CW'(1);
        end
      end
      if (state == IDLE_WAIT && next) begin
        base   <= phys(base, 2'd2);
        wr_row <= 2'd1;
      end
      if (state == REFILL && fill_end) k <= k + KW'(1);
      if (state == DONE) begin
        wr_row <= '0;
        k      <= '0;
      end
      if (state_nxt == STREAM) begin
        rd_col <= rd_nxt;
        en     <= (state != STREAM);
        row_0  <= mem[phys(base, 2'd0)][rd_nxt];
        row_1  <= mem[phys(base, 2'd1)][rd_nxt];
        row_2  <= final_trip ? pad_pix : mem[phys(base, 2'd2)][rd_nxt];
      end else begin
        rd_col <= '0;
        en     <= 1'b0;
      end
      frame_done <= (state_nxt == DONE) && (state != DONE);
    end
  end

endmodule

// File: tb/tb_row_bank.sv
// tb_row_bank: directed bench; dut4 (256x4) and dut6 (16x6) share stimulus, selected by sel.
module tb_row_bank;

`ifdef ROW_BANK_MIRROR_EN
  localparam bit PAD = 1'b0;
`else
  localparam bit PAD = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       next = 1'b0;

  logic       v4, v6, n4, n6;
  logic       rdy4, rdy6, en4, en6, busy4, busy6, fd4, fd6;
  logic [7:0] a0, a1, a2, b0, b1, b2;
  logic       rdy, en_o, busy_o, fd;
  logic [7:0] r0, r1, r2;

  int len = 256;
  int compared = 0;
  int mismatched = 0;

  assign v4 = pix_valid & ~sel;
  assign v6 = pix_valid & sel;
  assign n4 = next & ~sel;
  assign n6 = next & sel;

  assign rdy    = sel ? rdy6  : rdy4;
  assign en_o   = sel ? en6   : en4;
  assign busy_o = sel ? busy6 : busy4;
  assign fd     = sel ? fd6   : fd4;
  assign r0     = sel ? b0    : a0;
  assign r1     = sel ? b1    : a1;
  assign r2     = sel ? b2    : a2;

  row_bank #(.LENGTH(256), .HEIGHT(4)) dut4 (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(v4), .pix_ready(rdy4),
    .next(n4), .en(en4), .row_0(a0), .row_1(a1), .row_2(a2), .busy(busy4), .frame_done(fd4)
  );

  row_bank #(.LENGTH(16), .HEIGHT(6)) dut6 (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(v6), .pix_ready(rdy6),
    .next(n6), .en(en6), .row_0(b0), .row_1(b1), .row_2(b2), .busy(busy6), .frame_done(fd6)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 16 + c) & 8'hFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends nrows rows starting at first_row; gap inserts an idle cycle before each pixel.
  task automatic applyStimulus(input int first_row, input int nrows, input bit gap);
    int waits;
    for (int r = first_row; r < first_row + nrows; r++) begin
      for (int c = 0; c < len; c++) begin
        if (gap) begin
          pix_valid = 1'b0;
          @(negedge clk);
        end
        pix_in = pix(r, c);
        pix_valid = 1'b1;
        waits = 0;
        while (!rdy && waits < 50) begin
          @(negedge clk);
          waits++;
        end
        if (!rdy) begin
          checkOutput("ready_timeout", {31'd0, rdy}, 32'd1);
          pix_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic pulseNext();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  // Entered at stream column 0; returns at column 6 after a stray next pulse.
  task automatic checkTriplet(input int ra, input int rb, input int rc, input bit pad);
    checkOutput("en_c0", {31'd0, en_o}, 32'd1);
    checkOutput("row0_c0", {24'd0, r0}, {24'd0, pix(ra, 0)});
    checkOutput("row1_c0", {24'd0, r1}, {24'd0, pix(rb, 0)});
    checkOutput("row2_c0", {24'd0, r2}, pad ? 32'd0 : {24'd0, pix(rc, 0)});
    repeat (5) @(negedge clk);
    checkOutput("en_c5", {31'd0, en_o}, 32'd0);
    checkOutput("row0_c5", {24'd0, r0}, {24'd0, pix(ra, 5)});
    checkOutput("row1_c5", {24'd0, r1}, {24'd0, pix(rb, 5)});
    checkOutput("row2_c5", {24'd0, r2}, pad ? 32'd0 : {24'd0, pix(rc, 5)});
    pulseNext();
  endtask

  task automatic finishStream(input int ra, input int rc, input bit pad, input bit fin);
    repeat (len - 7) @(negedge clk);
    checkOutput("row0_last", {24'd0, r0}, {24'd0, pix(ra, len - 1)});
    checkOutput("row2_last", {24'd0, r2}, pad ? 32'd0 : {24'd0, pix(rc, len - 1)});
    checkOutput("busy_stream", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    checkOutput("en_after", {31'd0, en_o}, 32'd0);
    checkOutput("row0_hold", {24'd0, r0}, {24'd0, pix(ra, len - 1)});
    if (fin) begin
      checkOutput("frame_done_hi", {31'd0, fd}, 32'd1);
      checkOutput("busy_done", {31'd0, busy_o}, 32'd0);
      @(negedge clk);
      checkOutput("frame_done_lo", {31'd0, fd}, 32'd0);
      checkOutput("ready_refill_frame", {31'd0, rdy}, 32'd1);
    end else begin
      checkOutput("busy_idle", {31'd0, busy_o}, 32'd0);
      checkOutput("ready_idle", {31'd0, rdy}, 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_en", {31'd0, en_o}, 32'd0);
    checkOutput("rst_rows", {8'd0, r0, r1, r2}, 32'd0);
    checkOutput("rst_fd", {31'd0, fd}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd1);
    checkOutput("rst_ready", {31'd0, rdy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // dut4 frame 1, with stray next pulses in FILL and STREAM
    pulseNext();
    applyStimulus(0, 3, 1'b0);
    checkTriplet(0, 1, 2, 1'b0);
    finishStream(0, 2, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("idle_persist_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("idle_persist_ready", {31'd0, rdy}, 32'd0);
    pulseNext();
    checkOutput("refill_ready", {31'd0, rdy}, 32'd1);
    applyStimulus(3, 1, 1'b0);
    checkTriplet(2, 3, 2, PAD);
    finishStream(2, 2, PAD, 1'b1);

    // dut4 frame 2 with 50% valid, reset at column 100
    applyStimulus(0, 3, 1'b1);
    checkTriplet(0, 1, 2, 1'b0);
    repeat (94) @(negedge clk);
    checkOutput("row0_c100", {24'd0, r0}, {24'd0, pix(0, 100)});
    reset = 1'b1;
    #1;
    checkOutput("midrst_en", {31'd0, en_o}, 32'd0);
    checkOutput("midrst_rows", {8'd0, r0, r1, r2}, 32'd0);
    checkOutput("midrst_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // dut4 frame 3 after reset
    applyStimulus(0, 3, 1'b0);
    checkTriplet(0, 1, 2, 1'b0);
    finishStream(0, 2, 1'b0, 1'b0);

    // dut6: two back-to-back frames of three triplets
    sel = 1'b1;
    len = 16;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      applyStimulus(0, 3, 1'b0);
      checkTriplet(0, 1, 2, 1'b0);
      finishStream(0, 2, 1'b0, 1'b0);
      pulseNext();
      applyStimulus(3, 2, 1'b0);
      checkTriplet(2, 3, 4, 1'b0);
      finishStream(2, 4, 1'b0, 1'b0);
      pulseNext();
      applyStimulus(5, 1, 1'b0);
      checkTriplet(4, 5, 4, PAD);
      finishStream(4, 4, PAD, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
